dlfloat16_addsub_pipe: RTL and testbench

Pipelined, multi-lane DLFloat16 adder/subtractor with per-transaction op select, a valid/ready handshake and sticky exception flags. It is the successor to the single-lane combinational subtractor and serves as the add/sub unit of the PSIMD datapath. Each accepted transaction carries LANES independent operand pairs and produces LANES results three cycles later.

---
 rtl/dlfloat16_addsub_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_dlfloat16_addsub_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dlfloat16_addsub_pipe.sv
// Three-stage multi-lane DLFloat16 add/sub (align, add, normalise/pack) with global stall.
// Define DLF_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.

module dlfloat16_addsub_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en1_i,
  input  logic        en2_i,
  input  logic        en3_i,
  input  logic        op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] c_o,
  output logic [2:0]  flags_o
);
  // ---------------- S1: decode, specials, align ----------------
  logic [15:0] b_eff;
  logic        a_nan, b_nan, a_zero, b_zero, a_big;
  logic [14:0] big_mag, sml_mag;
  logic        big_sign;
  logic [5:0]  dexp;
  logic [23:0] shf;
  logic [12:0] sml_al;
  logic        spec_d;
  logic [15:0] sres_d;
  logic [2:0]  sflg_d;

  assign b_eff    = {b_i[15] ^ op_i, b_i[14:0]};
  assign a_nan    = (a_i == 16'hFFFF);
  assign b_nan    = (b_i == 16'hFFFF);
  assign a_zero   = (a_i[14:9] == 6'd0);
  assign b_zero   = (b_i[14:9] == 6'd0);
  assign a_big    = (a_i[14:0] >= b_eff[14:0]);
  assign big_mag  = a_big ? a_i[14:0] : b_eff[14:0];
  assign sml_mag  = a_big ? b_eff[14:0] : a_i[14:0];
  assign big_sign = a_big ? a_i[15] : b_eff[15];
  assign dexp     = big_mag[14:9] - sml_mag[14:9];
  // Significand plus guard/round, shifted through a 12-bit catch field for sticky.
  assign shf      = {1'b1, sml_mag[8:0], 2'b00, 12'd0} >> dexp;
  assign sml_al   = (dexp >= 6'd12) ? 13'd1 : {shf[23:12], |shf[11:0]};

  always_comb begin
    spec_d = 1'b1;
    sres_d = 16'h0000;
    sflg_d = 3'b000;
    if (a_nan || b_nan) begin
      sres_d = 16'hFFFF;
      sflg_d = 3'b100;
    end else if (a_zero && b_zero) begin
      sres_d = 16'h0000;
    end else if (a_zero) begin
      sres_d = b_eff;
    end else if (b_zero) begin
      sres_d = a_i;
    end else begin
      spec_d = 1'b0;
    end
  end

  logic        s1_spec_q, s1_sign_q, s1_sub_q;
  logic [15:0] s1_res_q;
  logic [2:0]  s1_flg_q;
  logic [5:0]  s1_exp_q;
  logic [9:0]  s1_big_q;
  logic [12:0] s1_sml_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_spec_q <= 1'b0;
      s1_res_q  <= '0;
      s1_flg_q  <= '0;
      s1_sign_q <= 1'b0;
      s1_sub_q  <= 1'b0;
      s1_exp_q  <= '0;
      s1_big_q  <= '0;
      s1_sml_q  <= '0;
    end else if (en1_i) begin
      s1_spec_q <= spec_d;
      s1_res_q  <= sres_d;
      s1_flg_q  <= sflg_d;
      s1_sign_q <= big_sign;
      s1_sub_q  <= a_i[15] ^ b_eff[15];
      s1_exp_q  <= big_mag[14:9];
      s1_big_q  <= {1'b1, big_mag[8:0]};
      s1_sml_q  <= sml_al;
    end
  end

  // ---------------- S2: magnitude add / subtract ----------------
  logic [13:0] sum_d;
  assign sum_d = s1_sub_q ? ({1'b0, s1_big_q, 3'b000} - {1'b0, s1_sml_q})
                          : ({1'b0, s1_big_q, 3'b000} + {1'b0, s1_sml_q});

  logic        s2_spec_q, s2_sign_q;
  logic [15:0] s2_res_q;
  logic [2:0]  s2_flg_q;
  logic [5:0]  s2_exp_q;
  logic [13:0] s2_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_spec_q <= 1'b0;
      s2_res_q  <= '0;
      s2_flg_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_sum_q  <= '0;
    end else if (en2_i) begin
      s2_spec_q <= s1_spec_q;
      s2_res_q  <= s1_res_q;
      s2_flg_q  <= s1_flg_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_sum_q  <= sum_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [3:0]        lz;
  logic [13:0]       norm;
  logic signed [7:0] exp_n, exp_f;
  logic [9:0]        sig_f;
  logic              unused_hid;

  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 14; i++)
      if (s2_sum_q[i]) lz = 4'(13 - i);
  end

  // Leading one lands on bit 13; bit 13 set pre-shift is the +1 carry case.
  assign norm  = s2_sum_q << lz;
  assign exp_n = $signed({2'b00, s2_exp_q}) + 8'sd1 - $signed({4'd0, lz});

`ifdef DLF_ADDSUB_RNE_EN
  logic        rnd_up;
  logic [10:0] sig_r;
  assign rnd_up = norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
  assign sig_r  = {1'b0, norm[13:4]} + {10'd0, rnd_up};
  assign sig_f  = sig_r[10] ? sig_r[10:1] : sig_r[9:0];
  assign exp_f  = exp_n + (sig_r[10] ? 8'sd1 : 8'sd0);
`else
  logic unused_grs;
  assign unused_grs = ^norm[3:0];
  assign sig_f      = norm[13:4];
  assign exp_f      = exp_n;
`endif
  assign unused_hid = sig_f[9];

  logic [15:0] c_d, c_q;
  logic [2:0]  f_d, f_q;

  always_comb begin
    c_d = {s2_sign_q, exp_f[5:0], sig_f[8:0]};
    f_d = 3'b000;
    if (s2_spec_q) begin
      c_d = s2_res_q;
      f_d = s2_flg_q;
    end else if (s2_sum_q == 14'd0) begin
      c_d = 16'h0000;
    end else if (exp_f >= 8'sd63) begin
      c_d = {s2_sign_q, 15'h7DFE};
      f_d = 3'b010;
    end else if (exp_f <= 8'sd0) begin
      c_d = {s2_sign_q, 15'h0201};
      f_d = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      f_q <= '0;
    end else if (en3_i) begin
      c_q <= c_d;
      f_q <= f_d;
    end
  end

  assign c_o     = c_q;
  assign flags_o = f_q;
endmodule

module dlfloat16_addsub_pipe #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [16*LANES-1:0]  in_a,
  input  logic [16*LANES-1:0]  in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  out_c,
  output logic [3*LANES-1:0]   out_flags,
  output logic [2:0]           sticky_flags,
  input  logic                 clr_flags
);
  localparam int STAGES = 3;

  logic [STAGES-1:0] vld_pipe_q;
  logic              advance;
  logic [2:0]        lane_or;
  logic [2:0]        sticky_q;

  // Global stall: every stage holds together, bubbles included.
  assign advance   = !vld_pipe_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else if (advance) vld_pipe_q <= {vld_pipe_q[STAGES-2:0], in_valid};
  end

  always_comb begin
    lane_or = 3'b000;
    for (int l = 0; l < LANES; l++) lane_or = lane_or | out_flags[3*l +: 3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else if (clr_flags) sticky_q <= '0;
    else if (out_valid && out_ready) sticky_q <= sticky_q | lane_or;
  end
  assign sticky_flags = sticky_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dlfloat16_addsub_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en1_i   (advance & in_valid),
      .en2_i   (advance & vld_pipe_q[0]),
      .en3_i   (advance & vld_pipe_q[1]),
      .op_i    (in_op),
      .a_i     (in_a[16*g +: 16]),
      .b_i     (in_b[16*g +: 16]),
      .c_o     (out_c[16*g +: 16]),
      .flags_o (out_flags[3*g +: 3])
    );
  end
endmodule

// File: tb/tb_dlfloat16_addsub_pipe.sv
// Directed vector table plus stall-stream and mid-flight reset sequences for dlfloat16_addsub_pipe.
module tb_dlfloat16_addsub_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b1, clr_flags = 1'b0;
  logic        in_ready, out_valid;
  logic [63:0] in_a = '0, in_b = '0, out_c;
  logic [11:0] out_flags;
  logic [2:0]  sticky_flags;

  int n_tests = 0, n_fail = 0;
  int j_in, j_out;
  logic [2:0]  sticky_m;
  logic [63:0] exp64;

`ifdef DLF_ADDSUB_RNE_EN
  localparam logic [15:0] V3L0 = 16'h3E02;
  localparam logic [15:0] V5L0 = 16'h7DFE;
  localparam logic [2:0]  V5F0 = 3'b010;
`else
  localparam logic [15:0] V3L0 = 16'h3E01;
  localparam logic [15:0] V5L0 = 16'h7DFF;
  localparam logic [2:0]  V5F0 = 3'b000;
`endif

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [11:0] f;
  } vec_t;
  vec_t vt [6];

  dlfloat16_addsub_pipe #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_flags(out_flags), .sticky_flags(sticky_flags), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] or_flags(input logic [11:0] f);
    return f[2:0] | f[5:3] | f[8:6] | f[11:9];
  endfunction

  // One transaction through an idle pipe; optional clear at start or on the delivery edge.
  task automatic run_vec(input int k, input logic clr_start, input logic clr_deliv);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = vt[k].op; in_a = vt[k].a; in_b = vt[k].b;
    clr_flags = clr_start;
    @(posedge clk); #1;
    if (clr_start) sticky_m = 3'b000;
    in_valid = 1'b0; clr_flags = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid before latency", k), {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", k), {63'd0, out_valid}, 64'd1);
    chk($sformatf("v%0d out_c", k), out_c, vt[k].c);
    chk($sformatf("v%0d out_flags", k), {52'd0, out_flags}, {52'd0, vt[k].f});
    clr_flags = clr_deliv;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    sticky_m = clr_deliv ? 3'b000 : (sticky_m | or_flags(vt[k].f));
    chk($sformatf("v%0d sticky", k), {61'd0, sticky_flags}, {61'd0, sticky_m});
    chk($sformatf("v%0d drained", k), {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, {4{16'h3E00}}, {4{16'h3E00}}, {4{16'h4000}}, 12'b000_000_000_000};
    vt[1] = '{1'b1, {16'h3E00, 16'h0000, 16'h3E00, 16'h4100},
                    {16'h0000, 16'h3E00, 16'h3E00, 16'h3E00},
                    {16'h3E00, 16'hBE00, 16'h0000, 16'h4000}, 12'b000_000_000_000};
    vt[2] = '{1'b0, {16'hBE00, 16'h0000, 16'hFFFF, 16'h7DFE},
                    {16'hBE00, 16'h0000, 16'h3E00, 16'h7DFE},
                    {16'hC000, 16'h0000, 16'hFFFF, 16'h7DFE}, 12'b000_000_100_010};
    vt[3] = '{1'b0, {16'h0001, 16'h4000, 16'h0300, 16'h3E01},
                    {16'h3E00, 16'h3E00, 16'h8200, 16'h2A00},
                    {16'h3E00, 16'h4100, 16'h0201, V3L0}, 12'b000_000_001_000};
    vt[4] = '{1'b1, {16'h3E00, 16'hFDFE, 16'h8000, 16'h3E00},
                    {16'hFFFF, 16'h7DFE, 16'h3E00, 16'h4000},
                    {16'hFFFF, 16'hFDFE, 16'hBE00, 16'hBE00}, 12'b100_010_000_000};
    vt[5] = '{1'b0, {16'h3E00, 16'h4000, 16'h3E00, 16'h7DFF},
                    {16'h3C00, 16'hC000, 16'h3E00, 16'h6800},
                    {16'h3F00, 16'h0000, 16'h4000, V5L0}, {9'b000_000_000, V5F0}};

    // Reset state
    #12;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_c", out_c, 64'd0);
    chk("reset out_flags", {52'd0, out_flags}, 64'd0);
    chk("reset sticky", {61'd0, sticky_flags}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    sticky_m = 3'b000;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_vec(k, 1'b1, 1'b0);
    run_vec(2, 1'b0, 1'b1);   // clear and delivery on the same edge: clear wins
    run_vec(2, 1'b0, 1'b0);   // accumulate again without clearing

    // Back-to-back stream of 8, out_ready low for cycles 4..6
    j_in = 0; j_out = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (j_in < 8);
      in_op     = 1'b0;
      for (int l = 0; l < 4; l++) begin
        in_a[16*l +: 16] = 16'h4000 + 16'(2 * (8 * l + j_in));
        in_b[16*l +: 16] = 16'h4000;
      end
      #1;
      chk($sformatf("stream c%0d in_ready", cyc), {63'd0, in_ready},
          (cyc >= 4 && cyc <= 6) ? 64'd0 : 64'd1);
      chk($sformatf("stream c%0d out_valid", cyc), {63'd0, out_valid},
          (cyc >= 3 && cyc <= 13) ? 64'd1 : 64'd0);
      if (out_valid) begin
        if (j_out < 8) begin
          for (int l = 0; l < 4; l++) exp64[16*l +: 16] = 16'h4200 + 16'(8 * l + j_out);
          chk($sformatf("stream c%0d out_c t%0d", cyc, j_out), out_c, exp64);
          chk($sformatf("stream c%0d flags", cyc), {52'd0, out_flags}, 64'd0);
        end else begin
          n_tests++; n_fail++;
          $display("FAIL stream extra result: got %h expected none", out_c);
        end
        if (out_ready) j_out++;
      end
      if (in_valid && in_ready) j_in++;
      @(posedge clk); #1;
    end
    chk("stream accepted count", 64'(j_in), 64'd8);
    chk("stream delivered count", 64'(j_out), 64'd8);

    // Reset with two transactions in flight, first one already at the output
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = vt[2].op; in_a = vt[2].a; in_b = vt[2].b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
    chk("pre-reset sticky", {61'd0, sticky_flags}, {61'd0, sticky_m});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("async reset sticky", {61'd0, sticky_flags}, 64'd0);
    chk("async reset out_c", out_c, 64'd0);
    chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset c%0d out_valid", c), {63'd0, out_valid}, 64'd0);
    end
    chk("post-reset sticky", {61'd0, sticky_flags}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
